rr_arbiter16: RTL and testbench

// - Round-robin arbiter that shares one resource among 16 requesters.
// - Registered 4-bit winner index drives a 16-bit one-hot grant vector (4-to-16 decode of gnt_idx).
// - The grant is held until the owner releases, drops its request or exceeds MAX_HOLD cycles.
// - Sits in front of shared register-file/bus write ports; grant lines feed the per-slot enables.

---
 rtl/rr_arbiter16_if.sv | 20 ++
 rtl/rr_arbiter16.sv | 100 ++++++++++
 tb/tb_rr_arbiter16.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between 16 requesters and the round-robin arbiter.
// "release" is a reserved word in SystemVerilog, so the owner-done strobe is named rel.
interface rr_arbiter16_if;
  logic [15:0] req;
  logic        rel;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  modport master (
    output req, rel,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, rel,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with hold-time limit and a mandatory dead
// cycle between grants; all state registered, gnt decoded from gnt_idx/gnt_valid.
module rr_arbiter16 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter16_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          ptr_q, ptr_d;
  logic [3:0]          idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                timeout_q, timeout_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                owner_req;
  logic                hold_max;

  // First set request bit scanning upward from one past the last winner, wrapping at 15.
  function automatic logic [3:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [3:0] idx;
    logic [3:0] win;
    logic       found;
    win   = p;
    found = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idx = p + 4'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign owner_req = bus.req[idx_q];
  assign hold_max  = (hold_q == HOLD_W'(MAX_HOLD));

  // NOTE: every always_comb output gets a default before the case, so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          idx_d   = rr_pick(bus.req, ptr_q);
          valid_d = 1'b1;
          hold_d  = HOLD_W'(1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.rel || !owner_req || hold_max) begin
          ptr_d     = idx_q;
          valid_d   = 1'b0;
          state_d   = GAP;
          // A release in the same cycle as the limit wins; only a forced revoke pulses.
          timeout_d = !bus.rel && owner_req && hold_max;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 4'hF;
      idx_q     <= 4'hF;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt       = valid_q ? (16'h0001 << idx_q) : 16'h0000;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic
// compared every cycle against a behavioural round-robin model.
module tb_rr_arbiter16;
  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  rr_arbiter16_if bus ();

  rr_arbiter16 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, for how long, and dead cycles still owed.
  bit m_owned;
  int m_owner;
  int m_last;
  int m_ptr;
  int m_held;
  int m_dead;
  bit m_timeout;

  int got[$];
  bit prev_valid;

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 1; k <= 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_owned = 0; m_owner = 15; m_last = 15; m_ptr = 15;
    m_held = 0; m_dead = 0; m_timeout = 0;
  endtask

  task automatic model_edge(input logic [15:0] r, input logic l);
    m_timeout = 0;
    if (m_owned) begin
      if (l || !r[m_owner] || m_held >= MAX_HOLD) begin
        m_timeout = !l && r[m_owner] && (m_held >= MAX_HOLD);
        m_owned = 0;
        m_ptr = m_owner;
        m_dead = 2;  // GAP, then the IDLE cycle that samples req
      end else begin
        m_held++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else if (r != 16'h0) begin
      m_dead = 0;
      m_owner = pick(r, m_ptr);
      m_owned = 1;
      m_held = 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [15:0] exp_gnt;
    exp_gnt = m_owned ? (16'h0001 << m_owner) : 16'h0000;
    check({tag, ".gnt"},     32'(bus.gnt),       32'(exp_gnt));
    check({tag, ".idx"},     32'(bus.gnt_idx),   32'(m_owner));
    check({tag, ".valid"},   32'(bus.gnt_valid), 32'(m_owned));
    check({tag, ".timeout"}, 32'(bus.timeout),   32'(m_timeout));
  endtask

  // Drive inputs, clock one edge, then compare 1 ns after the edge.
  task automatic step(input string tag, input logic [15:0] r, input logic l);
    bus.req = r;
    bus.rel = l;
    @(posedge clk);
    model_edge(r, l);
    #1;
    check_model(tag);
    if (bus.gnt_valid && !prev_valid) got.push_back(int'(bus.gnt_idx));
    prev_valid = bus.gnt_valid;
  endtask

  task automatic reset_dut();
    bus.req = '0;
    bus.rel = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    prev_valid = 0;
  endtask

  task automatic check_order(input string tag, input int exp[$]);
    check({tag, ".count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s.g%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    int hi_run;
    int to_cnt;
    bit dropped;
    logic [15:0] r;

    // Reset state
    reset_dut();
    check("rst.gnt", 32'(bus.gnt), 32'h0);
    check("rst.idx", 32'(bus.gnt_idx), 32'hF);
    check("rst.valid", 32'(bus.gnt_valid), 32'h0);
    check("rst.timeout", 32'(bus.timeout), 32'h0);

    // Single-cycle latency from IDLE
    step("lat", 16'h0001, 1'b0);
    check("lat.gnt_exact", 32'(bus.gnt), 32'h0001);

    // Two requesters, owner releases each grant
    reset_dut();
    for (int i = 0; i < 12; i++) step("alt", 16'h8001, m_owned);
    check_order("alt", '{0, 15, 0, 15});

    // Dead time after a release: GAP plus the IDLE sampling cycle
    reset_dut();
    step("dead", 16'h0004, 1'b0);
    step("dead", 16'h0004, 1'b1);
    check("dead.k1", 32'(bus.gnt_valid), 32'h0);
    step("dead", 16'h0004, 1'b0);
    check("dead.k2", 32'(bus.gnt_valid), 32'h0);
    step("dead", 16'h0004, 1'b0);
    check("dead.k3", 32'(bus.gnt_idx), 32'h2);

    // Ptr=0 then req 4003: 1, 14, then wrap through 15 to 0
    reset_dut();
    step("wrap0", 16'h0001, 1'b0);
    step("wrap0", 16'h0001, 1'b1);
    got.delete();
    for (int i = 0; i < 9; i++) step("wrap0", 16'h4003, m_owned);
    check_order("wrap0", '{1, 14, 0});

    // Ptr=14 then req 4003: scan starts at 15, wraps to 0 first
    reset_dut();
    step("wrap14", 16'h4000, 1'b0);
    step("wrap14", 16'h4000, 1'b1);
    got.delete();
    for (int i = 0; i < 9; i++) step("wrap14", 16'h4003, m_owned);
    check_order("wrap14", '{0, 1, 14});

    // Lone requester 5 never releases: 8 grant cycles, one timeout, re-grant to 5
    reset_dut();
    hi_run = 0; to_cnt = 0; dropped = 0;
    for (int i = 0; i < 11; i++) begin
      step("hold", 16'h0020, 1'b0);
      if (bus.gnt_valid && !dropped) hi_run++;
      if (!bus.gnt_valid && hi_run > 0) dropped = 1;
      if (bus.timeout) to_cnt++;
    end
    check("hold.cycles", 32'(hi_run), 32'(MAX_HOLD));
    check("hold.timeouts", 32'(to_cnt), 32'h1);
    check("hold.regrant", 32'(bus.gnt), 32'h0020);

    // Release on the limit cycle counts as a release: no timeout
    reset_dut();
    step("limrel", 16'h0020, 1'b0);
    for (int i = 0; i < MAX_HOLD - 1; i++) step("limrel", 16'h0020, 1'b0);
    step("limrel", 16'h0020, 1'b1);
    check("limrel.timeout", 32'(bus.timeout), 32'h0);

    // Owner 3 drops its request: revoke without timeout, ptr becomes 3
    reset_dut();
    step("drop", 16'h0008, 1'b0);
    step("drop", 16'h0008, 1'b0);
    step("drop", 16'h0000, 1'b0);
    check("drop.gnt", 32'(bus.gnt), 32'h0);
    check("drop.timeout", 32'(bus.timeout), 32'h0);
    step("drop", 16'hFFFF, 1'b0);
    step("drop", 16'hFFFF, 1'b0);
    check("drop.next", 32'(bus.gnt_idx), 32'h4);

    // Asynchronous reset between edges while BUSY
    reset_dut();
    step("arst", 16'h0200, 1'b0);
    step("arst", 16'h0200, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.gnt", 32'(bus.gnt), 32'h0);
    check("arst.idx", 32'(bus.gnt_idx), 32'hF);
    @(posedge clk);
    #1;
    check("arst.held", 32'(bus.gnt_valid), 32'h0);
    rst_n = 1'b1;
    prev_valid = 0;
    step("arst", 16'hFFFF, 1'b0);
    check("arst.first", 32'(bus.gnt_idx), 32'h0);

    // Random traffic against the model
    reset_dut();
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'($urandom());
        1:       r = 16'($urandom() & $urandom() & $urandom());
        2:       r = 16'h0001 << $urandom_range(0, 15);
        default: r = bus.req;
      endcase
      step("rand", r, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
